dcache_responder: RTL and testbench

Direct-mapped, read-allocate, write-through data cache that answers the memory-stage requests of the five-stage pipeline and drives its `CacheReady` stall handshake. It sits between the M stage (request side) and a single-word-per-beat main-memory port. It refills whole lines on read misses and forwards every store to memory. While `CacheReady` is low the pipeline holds the M stage.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_data_ram.sv | 24 ++
 rtl/dcache_responder.sv | 173 +++++++++++++++++
 tb/tb_dcache_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WSTORE
  } state_t;

  localparam int unsigned DEF_LINES = 16;
  localparam int unsigned DEF_WORDS = 4;
  localparam int unsigned OB        = 2 + $clog2(DEF_WORDS);
  localparam int unsigned IDX_W     = $clog2(DEF_LINES);
  localparam int unsigned TAG_W     = 32 - OB - IDX_W;

  // Generic bit-field extraction so instances with other LINES/WORDS can reuse it.
  function automatic logic [31:0] f_field(input logic [31:0] a,
                                          input int unsigned lsb,
                                          input int unsigned width);
    return (a >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

  function automatic logic [31:0] f_word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Cache data store: LINES x WORDS x 32, asynchronous read, synchronous write.
module dcache_data_ram #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic                     CLK,
  input  logic                     i_we,
  input  logic [$clog2(LINES)-1:0] i_wline,
  input  logic [$clog2(WORDS)-1:0] i_wword,
  input  logic [31:0]              i_wdata,
  input  logic [$clog2(LINES)-1:0] i_rline,
  input  logic [$clog2(WORDS)-1:0] i_rword,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [LINES*WORDS];

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[{i_wline, i_wword}] <= i_wdata;
  end

  assign o_rdata = r_mem[{i_rline, i_rword}];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, read-allocate, write-through data cache answering M-stage requests
// with a CacheReady stall handshake and a one-word-per-beat memory port.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        CacheReady,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned OW  = $clog2(WORDS);
  localparam int unsigned IW  = $clog2(LINES);
  localparam int unsigned OBL = 2 + OW;
  localparam int unsigned TW  = 32 - OBL - IW;

  state_t r_state, w_next;

  logic          r_valid [LINES];
  logic [TW-1:0] r_tag   [LINES];
  logic [OW-1:0] r_beat;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_rtag;
  logic          r_mem_req, r_mem_we;
  logic [31:0]   r_mem_addr, r_mem_wdata;

  logic [OW-1:0] w_off;
  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic          w_hit, w_last, w_rd_hit;
  logic          w_ram_we;
  logic [IW-1:0] w_ram_line;
  logic [OW-1:0] w_ram_word;
  logic [31:0]   w_ram_wdata, w_rdata;

  assign w_off  = OW'(f_field(Addr, 2, OW));
  assign w_idx  = IW'(f_field(Addr, OBL, IW));
  assign w_tag  = TW'(f_field(Addr, OBL + IW, TW));
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_last = (r_beat == OW'(WORDS - 1));

  always_ff @(posedge CLK) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    CacheReady = 1'b1;
    w_rd_hit   = 1'b0;
    case (r_state)
      IDLE: begin
        if (MemWrite) begin
          w_next     = WSTORE;
          CacheReady = 1'b0;
        end else if (MemRead) begin
          if (w_hit) begin
            w_rd_hit = 1'b1;
          end else begin
            w_next     = REFILL;
            CacheReady = 1'b0;
          end
        end
      end
      REFILL: begin
        CacheReady = 1'b0;
        if (mem_ack && w_last) w_next = IDLE;
      end
      WSTORE: begin
        CacheReady = mem_ack;
        if (mem_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // No request is present while reset is held, so report ready.
    if (reset) begin
      CacheReady = 1'b1;
      w_rd_hit   = 1'b0;
    end
  end

  assign ReadData = w_rd_hit ? w_rdata : '0;

  // The data array is shared: refill beats use the latched line, store hits use Addr.
  assign w_ram_we    = !reset && mem_ack &&
                       ((r_state == REFILL) || ((r_state == WSTORE) && w_hit));
  assign w_ram_line  = (r_state == REFILL) ? r_idx  : w_idx;
  assign w_ram_word  = (r_state == REFILL) ? r_beat : w_off;
  assign w_ram_wdata = (r_state == REFILL) ? mem_rdata : WriteData;

  dcache_data_ram #(.LINES(LINES), .WORDS(WORDS)) u_data (
    .CLK     (CLK),
    .i_we    (w_ram_we),
    .i_wline (w_ram_line),
    .i_wword (w_ram_word),
    .i_wdata (w_ram_wdata),
    .i_rline (w_idx),
    .i_rword (w_off),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int unsigned i = 0; i < LINES; i++) r_valid[i] <= 1'b0;
      r_beat      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (MemWrite) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= f_word_addr(Addr);
            r_mem_wdata <= WriteData;
          end else if (MemRead && !w_hit) begin
            r_valid[w_idx] <= 1'b0;
            r_idx          <= w_idx;
            r_rtag         <= w_tag;
            r_beat         <= '0;
            r_mem_req      <= 1'b1;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= {w_tag, w_idx, {OW{1'b0}}, 2'b00};
            r_mem_wdata    <= '0;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            if (w_last) begin
              r_valid[r_idx] <= 1'b1;
              r_tag[r_idx]   <= r_rtag;
              r_mem_req      <= 1'b0;
              r_mem_addr     <= '0;
            end else begin
              r_beat     <= r_beat + OW'(1);
              r_mem_addr <= {r_rtag, r_idx, r_beat + OW'(1), 2'b00};
            end
          end
        end
        WSTORE: begin
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: directed scenarios then randomized traffic
// checked against a residency/memory reference model.
module tb_dcache_responder;
  localparam int unsigned LINES = 16;
  localparam int unsigned WORDS = 4;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] Addr = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        CacheReady;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  dcache_responder #(.LINES(LINES), .WORDS(WORDS)) dut (
    .CLK(CLK), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .CacheReady(CacheReady),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  int unsigned n_tests = 0, n_fail = 0;
  int unsigned cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct { bit is_read; bit [31:0] addr; bit [31:0] data; int unsigned lat; } exp_t;
  typedef struct { bit we; bit [31:0] addr; bit [31:0] data; } beat_t;
  exp_t  sb_q[$];
  beat_t beat_q[$];

  bit [31:0] ref_mem [bit [31:0]];
  bit [31:0] phys    [bit [31:0]];
  bit        m_valid [LINES];
  bit [31:0] m_tag   [LINES];
  bit        busy = 1'b0;
  int unsigned start_cyc = 0;
  int unsigned acks = 0;

  function automatic bit [31:0] dflt(bit [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit [31:0] rd_ref(bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic check(string name, bit [31:0] act, bit [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: acks every requested beat in the cycle it is seen.
  always @(negedge CLK) begin
    beat_t b;
    if (!reset && mem_req) begin
      if (beat_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL beat_unexpected: got addr %h we %0d expected no beat", mem_addr, mem_we);
      end else begin
        b = beat_q.pop_front();
        check("beat_we", {31'd0, mem_we}, {31'd0, b.we});
        check("beat_addr", mem_addr, b.addr);
        if (b.we) check("beat_wdata", mem_wdata, b.data);
      end
      mem_ack = 1'b1;
      if (mem_we) begin
        phys[mem_addr] = mem_wdata;
        mem_rdata = '0;
      end else begin
        mem_rdata = phys.exists(mem_addr) ? phys[mem_addr] : dflt(mem_addr);
      end
      acks++;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end
  end

  // Monitor: pops the scoreboard when the DUT signals completion.
  always @(negedge CLK) begin
    exp_t e;
    #1;
    if (!reset) begin
      if (MemRead || MemWrite) begin
        if (busy && CacheReady) begin
          if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_empty: got completion at %h expected none", Addr);
          end else begin
            e = sb_q.pop_front();
            check(e.is_read ? "rd_latency" : "wr_latency", cyc - start_cyc, e.lat);
            check(e.is_read ? "rd_data" : "wr_rdata_zero", ReadData, e.data);
          end
          busy = 1'b0;
        end
      end else begin
        check("idle_ready", {31'd0, CacheReady}, 32'd1);
        check("idle_rdata", ReadData, 32'd0);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the completing edge.
  task automatic issue(bit rd, bit wr, bit [31:0] a, bit [31:0] d);
    exp_t e;
    int unsigned ix = (a >> 4) % LINES;
    bit [31:0] tg = a >> 8;
    bit [31:0] wa = a & ~32'd3;
    bit [31:0] base = a & ~32'd15;
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = d;
    if (wr) begin
      beat_q.push_back('{1'b1, wa, d});
      ref_mem[wa] = d;
      e = '{1'b0, a, 32'd0, 1};
    end else begin
      if (m_valid[ix] && m_tag[ix] == tg) begin
        e = '{1'b1, a, rd_ref(wa), 0};
      end else begin
        for (int w = 0; w < WORDS; w++) beat_q.push_back('{1'b0, base + 32'(4 * w), 32'd0});
        m_valid[ix] = 1'b1;
        m_tag[ix]   = tg;
        e = '{1'b1, a, rd_ref(wa), WORDS + 1};
      end
    end
    sb_q.push_back(e);
    start_cyc = cyc;
    busy = 1'b1;
    for (int k = 0; k < 60 && busy; k++) @(posedge CLK);
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: got no CacheReady for %h expected completion", a);
      busy = 1'b0;
      sb_q.delete();
      beat_q.delete();
    end
    #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    bit [31:0] a;
    int unsigned op;
    model_reset();
    for (int w = 0; w < 4; w++) begin
      ref_mem[32'h40 + 32'(4 * w)] = 32'h11 * 32'(w + 1);
      phys[32'h40 + 32'(4 * w)]    = 32'h11 * 32'(w + 1);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    check("rst_ready", {31'd0, CacheReady}, 32'd1);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_rdata", ReadData, 32'd0);
    @(posedge CLK); #1;
    reset = 1'b0;

    issue(1, 0, 32'h40, 0);          // cold miss
    issue(1, 0, 32'h48, 0);          // hit
    issue(0, 1, 32'h44, 32'hDEAD);   // write hit
    issue(1, 0, 32'h44, 0);
    issue(0, 1, 32'h200, 32'hBEEF);  // write miss, no allocate
    issue(1, 0, 32'h200, 0);
    issue(1, 0, 32'h140, 0);         // conflict eviction
    issue(1, 0, 32'h40, 0);
    issue(1, 1, 32'h4C, 32'h1234);   // write has priority

    // Reset in the middle of a refill.
    a = 32'hF40;
    for (int w = 0; w < WORDS; w++) beat_q.push_back('{1'b0, 32'hF40 + 32'(4 * w), 32'd0});
    acks = 0;
    MemRead = 1'b1; Addr = a;
    for (int k = 0; k < 20 && acks < 2; k++) @(posedge CLK);
    if (acks < 2) begin
      n_tests++; n_fail++;
      $display("FAIL refill_acks: got %0d acks expected 2", acks);
    end
    #1;
    reset = 1'b1; MemRead = 1'b0;
    @(negedge CLK); #1;
    check("midrst_ready", {31'd0, CacheReady}, 32'd1);
    check("midrst_rdata", ReadData, 32'd0);
    @(posedge CLK); #1;
    reset = 1'b0;
    beat_q.delete();
    model_reset();
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    issue(1, 0, a, 0);

    // Randomized traffic over a small address pool so hits, misses and conflicts mix.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end
      op = $urandom_range(0, 9);
      a  = 32'($urandom_range(0, 1023)) << 2;
      if (op < 3)       issue(0, 1, a, $urandom);
      else if (op == 3) issue(1, 1, a, $urandom);
      else              issue(1, 0, a, 0);
    end

    repeat (3) @(posedge CLK);
    check("sb_drained", sb_q.size(), 32'd0);
    check("beats_drained", beat_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
